// File: rtl/srl_fifo_pkg.sv
// Shared helpers for the SRL FIFO controller: ceiling log2 and the occupancy counter width.
package srl_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Counter needs one extra bit so that DEPTH itself (up to 2^ADDR_WIDTH) is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/srl_fifo_shiftreg.sv
// Pure SRL storage: shifts din into slot 0 on we and reads slot[addr] combinationally.
module srl_fifo_shiftreg
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] slot [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            slot[0] <= din;
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot[i] <= slot[i-1];
            end
        end
    end

    // Addresses beyond DEPTH only occur when the FIFO is empty, where dout is don't-care.
    always_comb begin
        dout = '0;
        if (int'(addr) < DEPTH) begin
            dout = slot[addr];
        end
    end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Shift-register FIFO controller: occupancy count, read address, registered full/empty flags.
// Optional macro SRL_FIFO_OCC_EN exposes if_num_data_valid and if_fifo_cap.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
`ifdef SRL_FIFO_OCC_EN
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
`else
    output logic                  if_empty_n
`endif
);

    localparam int CNT_W = count_width(ADDR_WIDTH);

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  wr_en, rd_en;
    logic [CNT_W-1:0]      addr_wide;
    logic [ADDR_WIDTH-1:0] addr;

    // Requests during the reset cycle are dropped so storage never shifts under reset.
    always_comb begin
        wr_en     = if_write & full_n_q & ~reset;
        rd_en     = if_read & empty_n_q & ~reset;
        count_d   = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_W'(DEPTH));
        addr_wide = count_q - CNT_W'(1);
        addr      = addr_wide[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (wr_en),
        .addr (addr),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;

`ifdef SRL_FIFO_OCC_EN
    assign if_num_data_valid = count_q;
    assign if_fifo_cap       = (ADDR_WIDTH + 1)'(DEPTH);
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard bench for srl_fifo_ctrl: queue-based reference model, directed plus random traffic.
module tb_srl_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 11;

    typedef struct packed {
        logic          empty_n;
        logic          full_n;
        logic [AW:0]   cnt;
    } flags_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write;
    logic          if_read;
    logic [DW-1:0] if_din;
    logic [DW-1:0] if_dout;
    logic          if_full_n;
    logic          if_empty_n;
`ifdef SRL_FIFO_OCC_EN
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q [$];
    flags_t        flag_q [$];
    flags_t        mon_e;
    logic [DW-1:0] mon_d;

    srl_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read           (if_read),
        .if_dout           (if_dout),
`ifdef SRL_FIFO_OCC_EN
        .if_empty_n        (if_empty_n),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap)
`else
        .if_empty_n        (if_empty_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of requests and advance the queue model to the post-edge state.
    task automatic apply_stimulus(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
        flags_t f;
        bit     acc_r;
        bit     acc_w;
        @(posedge clk);
        #1;
        reset    = rst;
        if_write = w;
        if_read  = r;
        if_din   = d;
        f.empty_n = (model_q.size() != 0);
        f.full_n  = (model_q.size() != DEPTH);
        f.cnt     = (AW + 1)'(model_q.size());
        flag_q.push_back(f);
        if (rst) begin
            model_q.delete();
        end else begin
            acc_r = r && (model_q.size() != 0);
            acc_w = w && (model_q.size() != DEPTH);
            if (acc_r) exp_q.push_back(model_q.pop_front());
            if (acc_w) model_q.push_back(d);
        end
    endtask

    // Monitor: flags every cycle, data whenever the DUT presents an accepted read.
    always @(negedge clk) begin
        if (flag_q.size() > 0) begin
            mon_e = flag_q.pop_front();
            check_output("empty_n", 32'(if_empty_n), 32'(mon_e.empty_n));
            check_output("full_n", 32'(if_full_n), 32'(mon_e.full_n));
`ifdef SRL_FIFO_OCC_EN
            check_output("num_data_valid", 32'(if_num_data_valid), 32'(mon_e.cnt));
            check_output("fifo_cap", 32'(if_fifo_cap), 32'(DEPTH));
`endif
        end
        if (reset === 1'b0 && if_read === 1'b1 && if_empty_n === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dout_unexpected actual=0x%0h expected=no_read at %0t", if_dout, $time);
            end else begin
                mon_d = exp_q.pop_front();
                check_output("dout", 32'(if_dout), 32'(mon_d));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        repeat (2) @(posedge clk);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);

        // Idle reads on an empty FIFO
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Fill, overflow attempt, drain
        for (int i = 1; i <= 11; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(i));
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 11; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Read+write while full: only the read is taken
        for (int i = 1; i <= 11; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(i));
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);

        // Read+write while empty: only the write is taken
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h55);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-stream at count 6
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'hEE);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h77);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic with varying bias and rare resets
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            apply_stimulus(($urandom_range(0, 299) == 0),
                           ($urandom_range(0, 3) < (bias + 1)),
                           ($urandom_range(0, 3) < (3 - bias)),
                           8'($urandom));
        end

        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check_output("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/srl_fifo_ctrl.md
# srl_fifo_ctrl

Controller for the shift-register FIFOs that carry start tokens and narrow data between dataflow processes (e.g. the PE_i4xi4 start channels of Linear_Layer_i4xi4_q). It instantiates the SRL storage and sequences it. It owns the occupancy counter, derives the read address and the registered full/empty flags, and applies the producer/consumer handshake rules so that the storage is never overwritten or over-read.

## Interface
Parameters:
- DATA_WIDTH, 1, token/data width in bits
- ADDR_WIDTH, 4, read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- DEPTH, 11, capacity in entries; legal range is 2 to 2^ADDR_WIDTH

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- if_write  in  1  producer write request
- if_din  in  DATA_WIDTH  producer data
- if_full_n  out  1  high when a write will be accepted
- if_read  in  1  consumer read/pop request
- if_dout  out  DATA_WIDTH  oldest entry (first-word-fall-through)
- if_empty_n  out  1  high when if_dout is valid and a read will be accepted

## Operation
- Accepted write: wr_en = if_write & if_full_n. The shift register shifts by one and if_din enters slot 0.
- Accepted read: rd_en = if_read & if_empty_n.
- Occupancy count, range 0..DEPTH (width ADDR_WIDTH+1):
  - wr_en only: count +1
  - rd_en only: count −1
  - both or neither: count unchanged
- Read address is addr = count − 1, truncated to ADDR_WIDTH bits. The address is meaningless when count == 0.
- if_dout = storage[addr], combinational from the current count. No output register.
- Flags are registered and computed from next_count:
  - if_empty_n <= (next_count != 0)
  - if_full_n <= (next_count != DEPTH)
- Boundary conditions:
  - Write while full: ignored; storage and count unchanged.
  - Read while empty: ignored.
  - Read and write while full: only the read is accepted (full_n is 0). Count drops to DEPTH−1.
  - Read and write while empty: only the write is accepted. Count becomes 1.
  - Read and write at 0 < count < DEPTH: shift and pop in the same cycle. Count and addr are unchanged, and the next-oldest word appears on if_dout.
- Reset (also mid-operation): count <= 0, if_empty_n <= 0, if_full_n <= 1. Storage contents are not cleared and are don't-care. Requests asserted in the reset cycle are ignored.

## Timing
- Write-to-read latency is 1 cycle. A write accepted in cycle t gives if_empty_n = 1 and valid if_dout in cycle t+1.
- A read accepted in cycle t presents the next entry on if_dout in cycle t+1.
- if_full_n falls in the cycle after the DEPTH-th accepted write. It rises in the cycle after the first read from full.
- Sustained throughput is 1 write and 1 read per cycle when not at a boundary.
- There is no combinational path from if_read to if_full_n, or from if_write to if_empty_n.

## Configuration
- SRL_FIFO_OCC_EN defined: adds output if_num_data_valid [ADDR_WIDTH:0] = count (registered) and output if_fifo_cap [ADDR_WIDTH:0] = DEPTH (constant).
- Undefined: these ports do not exist. Core behaviour is identical.

## Structure
- srl_fifo_pkg holds:
  - function clog2
  - localparam-style helper for the count width (ADDR_WIDTH+1)
- Sub-module srl_fifo_shiftreg (DATA_WIDTH, ADDR_WIDTH, DEPTH) contains the pure storage:
  - ports: clk, we, addr, din, dout
  - no reset
  - shifts on we; dout = slot[addr]
- The controller drives we = wr_en and addr = count−1.

## Test plan
Bench uses DATA_WIDTH=8, DEPTH=11.
- Reset, then idle: if_empty_n=0 and if_full_n=1. Any if_read is ignored; the flags stay unchanged for 5 cycles.
- Fill: write 0x01..0x0B on consecutive cycles. if_full_n=0 from the cycle after the 11th write. A 12th write of 0xFF is ignored. Reading 11 times returns 0x01..0x0B in order, and if_empty_n=0 after the last read.
- Simultaneous: preload 0x10..0x14 (count 5). Assert read+write with 0x20..0x24 for 5 cycles. Count stays 5, outputs are 0x10..0x14, then draining returns 0x20..0x24.
- Full + read + write: at count 11 with head 0x01, assert both with din 0xAA. Only the read is taken: if_dout becomes 0x02, if_full_n=1, and 0xAA is never read.
- Empty + read + write: at count 0, assert both with din 0x55. Next cycle if_empty_n=1, if_dout=0x55, count=1.
- Reset mid-stream: at count 6, assert reset for 1 cycle. Next cycle if_empty_n=0 and if_full_n=1. The next write 0x77 reads back as 0x77. With SRL_FIFO_OCC_EN defined, if_num_data_valid tracks 6 → 0 → 1.
